// File: rtl/uart_pkg.sv
// Shared types, frame geometry and helpers for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } state_t;

   localparam int NUM_REQ    = 3;
   localparam int FRAME_BITS = 12;
   localparam int DATA_BITS  = 8;
   // Start bit and parity bit are the two non-data, non-stop bits of a frame.
   localparam int STOP_BITS  = FRAME_BITS - DATA_BITS - 2;

   function automatic logic parity_even(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

   function automatic logic [1:0] rr_offset(input logic [1:0] base, input int unsigned off);
      int unsigned s;
      s = (32'(base) + off) % NUM_REQ;
      return s[1:0];
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1 while not cleared, tick marks the last cycle.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt_reg <= '0;
      end else if (cnt_reg == LAST_CNT) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign tick = !clear && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter for three byte requesters feeding one 8E2 UART transmitter.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   output logic [2:0] gnt,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

   state_t     state_reg, state_next;
   logic [1:0] last_winner_reg, last_winner_next;
   logic [2:0] bit_idx_reg, bit_idx_next;
   logic [7:0] byte_reg, byte_next;
   logic [2:0] gnt_reg, gnt_next;
   logic [1:0] grant_id_reg, grant_id_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic       tx_reg, tx_next;

   logic       tick;
   logic [1:0] winner;
   logic [1:0] cand [NUM_REQ];
   logic [7:0] data_arr [NUM_REQ];

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state_reg == ST_IDLE),
      .tick  (tick)
   );

   assign data_arr[0] = data0;
   assign data_arr[1] = data1;
   assign data_arr[2] = data2;

   // cand[0] is the highest-priority requester: the one after the last winner.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign cand[gi] = rr_offset(last_winner_reg, gi + 1);
      end
   endgenerate

   always_comb begin
      winner = cand[2];
      if (req[cand[0]]) begin
         winner = cand[0];
      end else if (req[cand[1]]) begin
         winner = cand[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         last_winner_reg <= 2'd2;
         bit_idx_reg     <= '0;
         byte_reg        <= '0;
         gnt_reg         <= '0;
         grant_id_reg    <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         tx_reg          <= 1'b1;
      end else begin
         state_reg       <= state_next;
         last_winner_reg <= last_winner_next;
         bit_idx_reg     <= bit_idx_next;
         byte_reg        <= byte_next;
         gnt_reg         <= gnt_next;
         grant_id_reg    <= grant_id_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
         tx_reg          <= tx_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      last_winner_next = last_winner_reg;
      bit_idx_next     = bit_idx_reg;
      byte_next        = byte_reg;
      gnt_next         = 3'b000;
      grant_id_next    = grant_id_reg;
      busy_next        = busy_reg;
      done_next        = 1'b0;
      tx_next          = tx_reg;

      case (state_reg)
         ST_IDLE: begin
            if (|req) begin
               byte_next        = data_arr[winner];
               gnt_next         = 3'b001 << winner;
               grant_id_next    = winner;
               last_winner_next = winner;
               busy_next        = 1'b1;
               tx_next          = 1'b0;
               bit_idx_next     = '0;
               state_next       = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               state_next   = ST_DATA;
               bit_idx_next = '0;
               tx_next      = byte_reg[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx_reg == LAST_DATA_IDX) begin
                  state_next = ST_PARITY;
                  tx_next    = parity_even(byte_reg);
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  tx_next      = byte_reg[bit_idx_reg + 3'd1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_next = ST_STOP1;
               tx_next    = 1'b1;
            end
         end
         ST_STOP1: begin
            if (tick) begin
               if (STOP_BITS > 1) begin
                  state_next = ST_STOP2;
               end else begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
               end
            end
         end
         ST_STOP2: begin
            if (tick) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               tx_next    = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign gnt      = gnt_reg;
   assign grant_id = grant_id_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign tx       = tx_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: the driver predicts each grant and frame, a monitor checks every cycle of tx/gnt/done/busy.
module tb_uart_tx_scheduler;
   import uart_pkg::*;

   localparam int CPB       = 4;
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = '0;
   logic [7:0] data0 = '0, data1 = '0, data2 = '0;
   logic [2:0] gnt;
   logic [1:0] grant_id;
   logic       busy, done, tx;

   uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .data0    (data0),
      .data1    (data1),
      .data2    (data2),
      .gnt      (gnt),
      .grant_id (grant_id),
      .busy     (busy),
      .done     (done),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] value;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec = 0;
   int         n_miss = 0;
   int         model_last = 2;
   logic [2:0] mask = '0;
   logic [7:0] bytes [3];
   logic       rst_applied = 1'b0;
   bit         exp_gnt_next = 1'b0;

   always @(posedge clk) rst_applied <= !rst_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: bound expired, got no completion, required completion (t=%0t)", name, $time);
   endtask

   // Reference arbitration: first requester found scanning upward from the one after the last winner.
   function automatic int predict(input logic [2:0] m);
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (model_last + k) % 3;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive_inputs();
      req   = mask;
      data0 = bytes[0];
      data1 = bytes[1];
      data2 = bytes[2];
   endtask

   task automatic push_pred();
      int w;
      exp_t e;
      w = predict(mask);
      e.id    = 2'(w);
      e.value = bytes[w];
      exp_q.push_back(e);
      model_last = w;
   endtask

   task automatic wait_gnt(output int w, output bit seen);
      seen = 1'b0;
      w = 0;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge clk);
         if (gnt != 3'b000) begin
            seen = 1'b1;
            w = gnt[0] ? 0 : (gnt[1] ? 1 : 2);
         end
      end
   endtask

   // One request round: raise mask, then after each grant either re-assert the winner (n_re times) or drop it.
   task automatic round(input logic [2:0] m, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int n_re, input bit rand_new,
                        input logic [7:0] fixed_new);
      int w;
      bit seen;
      int re_left;
      re_left = n_re;
      @(posedge clk); #1;
      mask = m;
      bytes[0] = b0;
      bytes[1] = b1;
      bytes[2] = b2;
      drive_inputs();
      push_pred();
      while (mask != 3'b000) begin
         wait_gnt(w, seen);
         if (!seen) begin
            timeout_fail("gnt_wait");
            mask = '0;
            drive_inputs();
            return;
         end
         @(posedge clk); #1;
         if (re_left > 0) begin
            re_left--;
            bytes[w] = rand_new ? 8'($urandom) : fixed_new;
         end else begin
            mask[w] = 1'b0;
         end
         drive_inputs();
         if (mask != 3'b000) push_pred();
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 600 && !ok; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !done) ok = 1'b1;
      end
      if (!ok) timeout_fail("idle_wait");
   endtask

   task automatic reset_mid_frame();
      int w;
      bit seen;
      wait_idle();
      @(posedge clk); #1;
      mask = 3'b001;
      bytes[0] = 8'($urandom);
      drive_inputs();
      push_pred();
      wait_gnt(w, seen);
      if (!seen) timeout_fail("gnt_wait_rst");
      @(posedge clk); #1;
      mask = '0;
      drive_inputs();
      // Reset is sampled 18 cycles after the grant edge: inside data bit 3.
      repeat (16) @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_last = 2;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic check_frame();
      exp_t e;
      logic [FRAME_BITS-1:0] bits;
      logic [5:0] expv;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL spurious_gnt: got gnt=%b, required no grant (t=%0t)", gnt, $time);
         return;
      end
      e = exp_q.pop_front();
      // Frame as transmitted, index = bit period: start, data LSB first, even parity, stop bits.
      bits[0] = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = e.value[i];
      bits[DATA_BITS + 1] = ($countones(e.value) % 2) == 1;
      for (int i = DATA_BITS + 2; i < FRAME_BITS; i++) bits[i] = 1'b1;
      $display("frame: requester %0d byte 0x%02h granted at t=%0t", e.id, e.value, $time);
      chk("gnt_onehot", 32'(gnt), 32'(3'b001 << e.id));
      chk("grant_id", 32'(grant_id), 32'(e.id));
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (c > 0) @(negedge clk);
         if (rst_applied) begin
            chk("abort_reset", 32'({tx, busy, gnt, done, grant_id}), 32'(8'b1000_0000));
            return;
         end
         expv = {(c == 0) ? (3'b001 << e.id) : 3'b000, 1'b0, 1'b1, bits[c / CPB]};
         chk($sformatf("req%0d_bit%0d", e.id, c / CPB), 32'({gnt, done, busy, tx}), 32'(expv));
      end
      @(negedge clk);
      if (rst_applied) begin
         chk("abort_reset", 32'({tx, busy, gnt, done, grant_id}), 32'(8'b1000_0000));
         return;
      end
      chk("frame_end", 32'({gnt, done, busy, tx}), 32'(6'b000_1_0_1));
      exp_gnt_next = (exp_q.size() != 0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_applied) begin
            exp_gnt_next = 1'b0;
            chk("reset_state", 32'({tx, busy, gnt, done, grant_id}), 32'(8'b1000_0000));
         end else if (gnt != 3'b000) begin
            exp_gnt_next = 1'b0;
            check_frame();
         end else begin
            if (exp_gnt_next && exp_q.size() != 0) begin
               chk("b2b_gnt", 32'(gnt), 32'(3'b001 << exp_q[0].id));
            end
            exp_gnt_next = 1'b0;
            chk("idle_outputs", 32'({gnt, done, busy, tx}), 32'(6'b000_0_0_1));
         end
      end
   end

   initial begin : driver
      bytes[0] = '0;
      bytes[1] = '0;
      bytes[2] = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All three held, each re-asserted after its grant: order 0,1,2,0,1,2.
      round(3'b111, 8'($urandom), 8'($urandom), 8'($urandom), 3, 1'b1, 8'h00);
      wait_idle();
      round(3'b001, 8'hA5, 8'($urandom), 8'($urandom), 0, 1'b1, 8'h00);
      wait_idle();
      round(3'b100, 8'($urandom), 8'($urandom), 8'h07, 0, 1'b1, 8'h00);
      wait_idle();
      round(3'b100, 8'($urandom), 8'($urandom), 8'h00, 0, 1'b1, 8'h00);
      reset_mid_frame();
      round(3'b011, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b1, 8'h00);
      wait_idle();
      // data1 changes to 0xFF on the cycle after gnt with req1 still high.
      round(3'b010, 8'($urandom), 8'h3C, 8'($urandom), 1, 1'b0, 8'hFF);

      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 60)) @(posedge clk);
         round(3'($urandom_range(1, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 3)), 1'b1, 8'h00);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
